// File: rtl/rf_operand_fetch.sv
// rtl/rf_operand_fetch.sv - operand fetch with busy-bit scoreboard and a one-entry valid/ready output stage
// Optional macro WB_BYPASS_EN forwards the writeback bus into same-cycle operand reads.
`ifndef RF_SIZE_LOG
`define RF_SIZE_LOG 5
`endif
`ifndef REG_LEN
`define REG_LEN 32
`endif

module rf_operand_fetch #(
  parameter int RF_SIZE_LOG = `RF_SIZE_LOG,
  parameter int REG_LEN     = `REG_LEN,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RF_SIZE_LOG-1:0] in_rs1,
  input  logic [RF_SIZE_LOG-1:0] in_rs2,
  input  logic [RF_SIZE_LOG-1:0] in_rd,
  input  logic                   in_rd_wen,
  output logic [RF_SIZE_LOG-1:0] rf_rs1,
  input  logic [REG_LEN-1:0]     rf_rs1_data,
  output logic [RF_SIZE_LOG-1:0] rf_rs2,
  input  logic [REG_LEN-1:0]     rf_rs2_data,
  input  logic                   wb_valid,
  input  logic [RF_SIZE_LOG-1:0] wb_rd,
  input  logic [REG_LEN-1:0]     wb_data,
  output logic                   rf_wen,
  output logic [RF_SIZE_LOG-1:0] rf_rd,
  output logic [REG_LEN-1:0]     rf_rd_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REG_LEN-1:0]     out_rs1_data,
  output logic [REG_LEN-1:0]     out_rs2_data,
  output logic [RF_SIZE_LOG-1:0] out_rd,
  output logic                   out_rd_wen,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int RF_SIZE = 2 ** RF_SIZE_LOG;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state, state_nxt;
  logic [RF_SIZE-1:0]   busy, busy_nxt;
  logic                 byp1, byp2, busy1, busy2;
  logic                 hazard, space, fire, stall_inc;
  logic [REG_LEN-1:0]   op1, op2;

  assign rf_rs1     = in_rs1;
  assign rf_rs2     = in_rs2;
  assign rf_wen     = wb_valid;
  assign rf_rd      = wb_rd;
  assign rf_rd_data = wb_data;

`ifdef WB_BYPASS_EN
  assign byp1 = wb_valid && (wb_rd == in_rs1);
  assign byp2 = wb_valid && (wb_rd == in_rs2);
  assign op1  = byp1 ? wb_data : rf_rs1_data;
  assign op2  = byp2 ? wb_data : rf_rs2_data;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign op1  = rf_rs1_data;
  assign op2  = rf_rs2_data;
`endif

  // WAW check on in_rd deliberately ignores the bypass terms.
  assign busy1     = busy[in_rs1] & ~byp1;
  assign busy2     = busy[in_rs2] & ~byp2;
  assign hazard    = busy1 | busy2 | (in_rd_wen & busy[in_rd]);
  assign out_valid = (state == FULL);
  assign space     = ~out_valid | out_ready;
  assign in_ready  = space & ~hazard & ~flush;
  assign fire      = in_valid & in_ready;
  assign stall_inc = in_valid & space & hazard & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)          state_nxt = EMPTY;
    else if (fire)      state_nxt = FULL;
    else if (out_ready) state_nxt = EMPTY;
  end

  // Clear before set so an issue and a writeback to the same index leave it busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid)          busy_nxt[wb_rd] = 1'b0;
    if (fire && in_rd_wen) busy_nxt[in_rd] = 1'b1;
    if (flush)             busy_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_rd_wen   <= 1'b0;
    end else if (fire) begin
      out_rs1_data <= op1;
      out_rs2_data <= op2;
      out_rd       <= in_rd;
      out_rd_wen   <= in_rd_wen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            stall_cnt <= '0;
    else if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// tb/tb_rf_operand_fetch.sv - directed self-checking bench for rf_operand_fetch
// Builds with or without WB_BYPASS_EN; the RAW step picks its expectations accordingly.
`timescale 1ns/1ps

module tb_rf_operand_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [1:0] in_rs1, in_rs2, in_rd;
  logic       in_rd_wen;
  logic [1:0] rf_rs1, rf_rs2;
  logic [7:0] rf_rs1_data, rf_rs2_data;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic       rf_wen;
  logic [1:0] rf_rd;
  logic [7:0] rf_rd_data;
  logic       flush;
  logic       out_valid, out_ready;
  logic [7:0] out_rs1_data, out_rs2_data;
  logic [1:0] out_rd;
  logic       out_rd_wen;
  logic [3:0] stall_cnt;

  logic [7:0] rf_mem [4];
  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int exp_stall;

  always #5 clk = ~clk;

  // Register file model fed only by the DUT's write port.
  always @(posedge clk) if (rf_wen) rf_mem[rf_rd] <= rf_rd_data;
  assign rf_rs1_data = rf_mem[rf_rs1];
  assign rf_rs2_data = rf_mem[rf_rs2];

  rf_operand_fetch #(.RF_SIZE_LOG(2), .REG_LEN(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .rf_rs1(rf_rs1), .rf_rs1_data(rf_rs1_data),
    .rf_rs2(rf_rs2), .rf_rs2_data(rf_rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_wen = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_rs1_data", 32'(out_rs1_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Preload RF[1]=0x11, RF[2]=0x22 through the writeback passthrough
    wb_valid = 1'b1; wb_rd = 2'd1; wb_data = 8'h11;
    #1;
    chk("wb_rf_wen", 32'(rf_wen), 32'd1);
    chk("wb_rf_rd", 32'(rf_rd), 32'd1);
    chk("wb_rf_rd_data", 32'(rf_rd_data), 32'h11);
    tick();
    wb_rd = 2'd2; wb_data = 8'h22;
    tick();
    wb_valid = 1'b0;

    // Issue rs1=1 rs2=2 rd=3
    in_valid = 1'b1; in_rs1 = 2'd1; in_rs2 = 2'd2; in_rd = 2'd3; in_rd_wen = 1'b1; out_ready = 1'b1;
    #1;
    chk("issue_in_ready", 32'(in_ready), 32'd1);
    chk("issue_rf_rs1", 32'(rf_rs1), 32'd1);
    chk("issue_rf_rs2", 32'(rf_rs2), 32'd2);
    tick();
    chk("issue_out_valid", 32'(out_valid), 32'd1);
    chk("issue_rs1_data", 32'(out_rs1_data), 32'h11);
    chk("issue_rs2_data", 32'(out_rs2_data), 32'h22);
    chk("issue_out_rd", 32'(out_rd), 32'd3);
    chk("issue_out_rd_wen", 32'(out_rd_wen), 32'd1);

    // RAW on rd=3
    in_rs1 = 2'd3; in_rs2 = 2'd1; in_rd = 2'd0; in_rd_wen = 1'b0;
    #1 chk("raw_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("raw_drain_out_valid", 32'(out_valid), 32'd0);
    chk("raw_stall_1", 32'(stall_cnt), 32'd1);
    tick();
    chk("raw_stall_2", 32'(stall_cnt), 32'd2);
    wb_valid = 1'b1; wb_rd = 2'd3; wb_data = 8'h5A;
    #1 chk("raw_rf_wen_T", 32'(rf_wen), 32'd1);
`ifdef WB_BYPASS_EN
    chk("byp_in_ready_T", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    exp_stall = 2;
`else
    chk("nobyp_in_ready_T", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    exp_stall = 3;
    #1;
    chk("nobyp_in_ready_T1", 32'(in_ready), 32'd1);
    chk("nobyp_stall_T1", 32'(stall_cnt), 32'(exp_stall));
    tick();
    in_valid = 1'b0;
`endif
    #1;
    chk("raw_out_valid", 32'(out_valid), 32'd1);
    chk("raw_rs1_data", 32'(out_rs1_data), 32'h5A);
    chk("raw_rs2_data", 32'(out_rs2_data), 32'h11);
    chk("raw_stall_final", 32'(stall_cnt), 32'(exp_stall));

    // Backpressure for 3 cycles, then back-to-back transfer
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs1 = 2'd1; in_rs2 = 2'd2; in_rd = 2'd2; in_rd_wen = 1'b1;
    #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_rs1_stable", 32'(out_rs1_data), 32'h5A);
      chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("b2b_out_valid", 32'(out_valid), 32'd1);
    chk("b2b_rs1_data", 32'(out_rs1_data), 32'h11);
    chk("b2b_rs2_data", 32'(out_rs2_data), 32'h22);
    chk("b2b_out_rd", 32'(out_rd), 32'd2);
    chk("b2b_stall", 32'(stall_cnt), 32'(exp_stall));

    // rs1 == rs2, sets busy[3]
    in_rs1 = 2'd1; in_rs2 = 2'd1; in_rd = 2'd3; in_rd_wen = 1'b1;
    #1 chk("same_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("same_rs1_data", 32'(out_rs1_data), 32'h11);
    chk("same_rs2_data", 32'(out_rs2_data), 32'h11);
    chk("same_out_rd", 32'(out_rd), 32'd3);

    // Flush while FULL with busy[2], busy[3] set
    out_ready = 1'b0; flush = 1'b1;
    in_rs1 = 2'd3; in_rs2 = 2'd2; in_rd = 2'd0; in_rd_wen = 1'b0;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    #1;
    chk("flush_busy_cleared", 32'(in_ready), 32'd1);
    chk("flush_stall", 32'(stall_cnt), 32'(exp_stall));
    tick();
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    chk("post_flush_rs1", 32'(out_rs1_data), 32'h5A);
    chk("post_flush_rs2", 32'(out_rs2_data), 32'h22);

    // WAW on rd=2
    out_ready = 1'b1;
    in_rs1 = 2'd1; in_rs2 = 2'd1; in_rd = 2'd2; in_rd_wen = 1'b1;
    #1 chk("waw_setup_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("waw_in_ready", 32'(in_ready), 32'd0);
    in_rd_wen = 1'b0;
    #1 chk("waw_nowen_in_ready", 32'(in_ready), 32'd1);

    // Issue to rd=1 on the same edge as a writeback to 1: set wins
    in_rs1 = 2'd3; in_rs2 = 2'd3; in_rd = 2'd1; in_rd_wen = 1'b1;
    wb_valid = 1'b1; wb_rd = 2'd1; wb_data = 8'h77;
    #1 chk("setwin_issue_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    in_rs1 = 2'd1; in_rs2 = 2'd3; in_rd = 2'd0; in_rd_wen = 1'b0;
    #1;
    chk("setwin_busy", 32'(in_ready), 32'd0);
    chk("setwin_rs1_data", 32'(out_rs1_data), 32'h5A);

    // Saturate stall_cnt
    for (int i = 0; i < 20; i++) tick();
    chk("stall_saturate", 32'(stall_cnt), 32'hF);
    chk("stall_hold_in_ready", 32'(in_ready), 32'd0);

    // Async reset while FULL
    in_rs1 = 2'd3; in_rs2 = 2'd3;
    #1 chk("arst_setup_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("arst_full", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    chk("arst_rs1_data", 32'(out_rs1_data), 32'd0);
    in_rs1 = 2'd1;
    #1 chk("arst_busy_cleared", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
